// File: rtl/aurora_rx_deframer_if.sv
`default_nettype none
// ============================================================================
// Module      : aurora_rx_deframer_if
// Description : Bus bundle between the Aurora RX user stream, the receive
//               deframer and the local receive FIFO / flow-control logic.
//               Optional statistics signals exist when AURORA_RX_STATS_EN
//               is defined.
// Revision    : 1.0  initial release
// ============================================================================
interface aurora_rx_deframer_if #(
   parameter int LEN_W = 18
);
   // Aurora RX user stream (no backpressure)
   logic [31:0]      rx_data;
   logic             rx_data_src_rdy;
   // Receive FIFO write port
   logic             fifo_wr;
   logic [31:0]      fifo_dat;
   logic             fifo_full;
   // Flow-control credit and status
   logic [LEN_W-1:0] partner_empty_slots;
   logic             partner_empty_slots_valid;
   logic             in_packet;
   logic             err_overflow;
   logic             err_header;
`ifdef AURORA_RX_STATS_EN
   logic [31:0]      stat_data_words;
   logic [31:0]      stat_ctrl_words;
   logic [31:0]      stat_pkts;

   // Stream source / FIFO owner side
   modport master (
      output rx_data, rx_data_src_rdy, fifo_full,
      input  fifo_wr, fifo_dat, partner_empty_slots, partner_empty_slots_valid,
             in_packet, err_overflow, err_header,
             stat_data_words, stat_ctrl_words, stat_pkts
   );
   // Deframer side
   modport slave (
      input  rx_data, rx_data_src_rdy, fifo_full,
      output fifo_wr, fifo_dat, partner_empty_slots, partner_empty_slots_valid,
             in_packet, err_overflow, err_header,
             stat_data_words, stat_ctrl_words, stat_pkts
   );
`else
   // Stream source / FIFO owner side
   modport master (
      output rx_data, rx_data_src_rdy, fifo_full,
      input  fifo_wr, fifo_dat, partner_empty_slots, partner_empty_slots_valid,
             in_packet, err_overflow, err_header
   );
   // Deframer side
   modport slave (
      input  rx_data, rx_data_src_rdy, fifo_full,
      output fifo_wr, fifo_dat, partner_empty_slots, partner_empty_slots_valid,
             in_packet, err_overflow, err_header
   );
`endif
endinterface
`default_nettype wire

// File: rtl/aurora_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module      : aurora_rx_deframer
// Description : Receive-side deframer of the Aurora framed link. Control
//               words forward the partner's free-slot count as flow-control
//               credit; data headers announce N payload words which are
//               written to the local receive FIFO. Unknown header tags and
//               FIFO overflow are flagged.
//               Optional macro AURORA_RX_STATS_EN adds event counters.
// Revision    : 1.0  initial release
// ============================================================================
module aurora_rx_deframer #(
   parameter int                HEAD_W   = 4,
   parameter logic [HEAD_W-1:0] CTRL_TAG = 4'hC,
   parameter logic [HEAD_W-1:0] DATA_TAG = 4'hD,
   parameter int                LEN_W    = 18
) (
   input  wire logic             clk_i,
   input  wire logic             reset_i,
   aurora_rx_deframer_if.slave   bus
);

   typedef enum logic [0:0] {
      ST_HEAD = 1'b0,
      ST_DATA = 1'b1
   } state_t;

   localparam logic [LEN_W-1:0] c_len_one = {{(LEN_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_state_next;
   logic [LEN_W-1:0] r_remaining;
   logic [LEN_W-1:0] w_remaining_next;

   logic             r_fifo_wr;
   logic             w_fifo_wr_next;
   logic [31:0]      r_fifo_dat;
   logic [31:0]      w_fifo_dat_next;
   logic [LEN_W-1:0] r_slots;
   logic [LEN_W-1:0] w_slots_next;
   logic             r_slots_valid;
   logic             w_slots_valid_next;
   logic             r_err_overflow;
   logic             w_err_overflow_next;
   logic             r_err_header;
   logic             w_err_header_next;

   logic [31:0]      w_word;
   logic [HEAD_W-1:0] w_tag;
   logic [LEN_W-1:0] w_len;

   // Field extraction; bits between the tag and the length are reserved
   assign w_word = bus.rx_data;
   assign w_tag  = w_word[31 -: HEAD_W];
   assign w_len  = w_word[LEN_W-1:0];

   // State register and all registered outputs
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state        <= ST_HEAD;
         r_remaining    <= '0;
         r_fifo_wr      <= 1'b0;
         r_fifo_dat     <= '0;
         r_slots        <= '0;
         r_slots_valid  <= 1'b0;
         r_err_overflow <= 1'b0;
         r_err_header   <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_remaining    <= w_remaining_next;
         r_fifo_wr      <= w_fifo_wr_next;
         r_fifo_dat     <= w_fifo_dat_next;
         r_slots        <= w_slots_next;
         r_slots_valid  <= w_slots_valid_next;
         r_err_overflow <= w_err_overflow_next;
         r_err_header   <= w_err_header_next;
      end
   end

   // Next-state and next-output decode; idle cycles only clear the pulses
   always_comb begin
      w_state_next        = r_state;
      w_remaining_next    = r_remaining;
      w_fifo_wr_next      = 1'b0;
      w_fifo_dat_next     = r_fifo_dat;
      w_slots_next        = r_slots;
      w_slots_valid_next  = 1'b0;
      w_err_overflow_next = r_err_overflow;
      w_err_header_next   = 1'b0;

      if (bus.rx_data_src_rdy) begin
         case (r_state)
            ST_HEAD: begin
               if (w_tag == CTRL_TAG) begin
                  w_slots_next       = w_len;
                  w_slots_valid_next = 1'b1;
               end else if (w_tag == DATA_TAG) begin
                  // A zero-length packet is consumed without leaving HEAD
                  if (w_len != '0) begin
                     w_remaining_next = w_len;
                     w_state_next     = ST_DATA;
                  end
               end else begin
                  w_err_header_next = 1'b1;
               end
            end
            ST_DATA: begin
               // Payload is never decoded as a header, whatever its tag
               if (bus.fifo_full) begin
                  w_err_overflow_next = 1'b1;
               end else begin
                  w_fifo_wr_next  = 1'b1;
                  w_fifo_dat_next = w_word;
               end
               // Dropped words still count; leaving at 1 keeps it from wrapping
               w_remaining_next = r_remaining - c_len_one;
               if (r_remaining == c_len_one) begin
                  w_state_next = ST_HEAD;
               end
            end
            default: begin
               w_state_next     = ST_HEAD;
               w_remaining_next = '0;
            end
         endcase
      end
   end

   assign bus.fifo_wr                   = r_fifo_wr;
   assign bus.fifo_dat                  = r_fifo_dat;
   assign bus.partner_empty_slots       = r_slots;
   assign bus.partner_empty_slots_valid = r_slots_valid;
   assign bus.in_packet                 = (r_state == ST_DATA);
   assign bus.err_overflow              = r_err_overflow;
   assign bus.err_header                = r_err_header;

`ifdef AURORA_RX_STATS_EN
   logic [31:0] r_stat_data_words;
   logic [31:0] r_stat_ctrl_words;
   logic [31:0] r_stat_pkts;

   // Free-running event counters, wrapping modulo 2^32
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_stat_data_words <= '0;
         r_stat_ctrl_words <= '0;
         r_stat_pkts       <= '0;
      end else begin
         if (w_fifo_wr_next) begin
            r_stat_data_words <= r_stat_data_words + 32'd1;
         end
         if (w_slots_valid_next) begin
            r_stat_ctrl_words <= r_stat_ctrl_words + 32'd1;
         end
         if ((r_state == ST_HEAD) && (w_state_next == ST_DATA)) begin
            r_stat_pkts <= r_stat_pkts + 32'd1;
         end
      end
   end

   assign bus.stat_data_words = r_stat_data_words;
   assign bus.stat_ctrl_words = r_stat_ctrl_words;
   assign bus.stat_pkts       = r_stat_pkts;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aurora_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aurora_rx_deframer
// Description : Self-checking bench for aurora_rx_deframer. A table of
//               per-cycle stimulus/expected-output records drives the main
//               sequences; FIFO writes are checked against a scoreboard
//               queue; reset mid-packet is a hand-written sequence.
// Revision    : 1.0  initial release
// ============================================================================
module tb_aurora_rx_deframer;

   typedef struct packed {
      logic [31:0] data;
      logic        rdy;
      logic        full;
      logic        wr;      // expected fifo_wr after the edge
      logic [31:0] dat;     // expected fifo_dat when wr
      logic        sv;      // expected partner_empty_slots_valid
      logic [17:0] slots;   // expected partner_empty_slots
      logic        inp;     // expected in_packet
      logic        eh;      // expected err_header
      logic        eo;      // expected err_overflow
   } vec_t;

   localparam int NVEC = 24;

   logic clk_i   = 1'b0;
   logic reset_i = 1'b1;

   aurora_rx_deframer_if #(.LEN_W(18)) bus ();

   aurora_rx_deframer dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .bus     (bus.slave)
   );

   always #5 clk_i = ~clk_i;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [31:0] sb_q[$];
   vec_t        vecs[NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive at negedge, sample 1 time unit after the rising edge
   task automatic drive(input logic [31:0] d, input logic rdy, input logic full, input logic rst);
      @(negedge clk_i);
      bus.rx_data         = d;
      bus.rx_data_src_rdy = rdy;
      bus.fifo_full       = full;
      reset_i             = rst;
      @(posedge clk_i);
      #1;
   endtask

   // Pop the scoreboard whenever the DUT writes the FIFO
   task automatic check_fifo(input string name, input logic exp_wr);
      logic [31:0] exp_d;
      chk({name, ".fifo_wr"}, 32'(bus.fifo_wr), 32'(exp_wr));
      if (bus.fifo_wr) begin
         if (sb_q.size() == 0) begin
            chk({name, ".unexpected_write"}, bus.fifo_dat, 32'hFFFF_FFFF ^ bus.fifo_dat);
         end else begin
            exp_d = sb_q.pop_front();
            chk({name, ".fifo_dat"}, bus.fifo_dat, exp_d);
         end
      end else if (exp_wr && sb_q.size() > 0) begin
         exp_d = sb_q.pop_front();
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      string nm;
      nm = $sformatf("vec%0d", idx);
      if (v.wr) sb_q.push_back(v.dat);
      drive(v.data, v.rdy, v.full, 1'b0);
      check_fifo(nm, v.wr);
      chk({nm, ".slots_valid"}, 32'(bus.partner_empty_slots_valid), 32'(v.sv));
      chk({nm, ".slots"}, 32'(bus.partner_empty_slots), 32'(v.slots));
      chk({nm, ".in_packet"}, 32'(bus.in_packet), 32'(v.inp));
      chk({nm, ".err_header"}, 32'(bus.err_header), 32'(v.eh));
      chk({nm, ".err_overflow"}, 32'(bus.err_overflow), 32'(v.eo));
   endtask

   initial begin
      //                data          rdy   full  wr    dat           sv    slots    inp   eh    eo
      // control word, idle, 3-word packet, back-to-back control
      vecs[0]  = '{32'hC000_0123, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 18'h123, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{32'hC000_0999, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 18'h123, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{32'hD000_0003, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 18'h123, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{32'hAAAA_0001, 1'b1, 1'b0, 1'b1, 32'hAAAA_0001, 1'b0, 18'h123, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{32'hAAAA_0002, 1'b1, 1'b0, 1'b1, 32'hAAAA_0002, 1'b0, 18'h123, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{32'hAAAA_0003, 1'b1, 1'b0, 1'b1, 32'hAAAA_0003, 1'b0, 18'h123, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{32'hC000_0010, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 18'h010, 1'b0, 1'b0, 1'b0};
      // len=2 with idle gaps; second payload carries a control-looking tag
      vecs[7]  = '{32'hD000_0002, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 18'h010, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 18'h010, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{32'hC000_0777, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 18'h010, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{32'hBBBB_0001, 1'b1, 1'b0, 1'b1, 32'hBBBB_0001, 1'b0, 18'h010, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{32'h5555_5555, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 18'h010, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{32'hD000_0001, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 18'h010, 1'b1, 1'b0, 1'b0};
      vecs[13] = '{32'hC000_0002, 1'b1, 1'b0, 1'b1, 32'hC000_0002, 1'b0, 18'h010, 1'b0, 1'b0, 1'b0};
      // zero-length packet, control, unknown tag, idle
      vecs[14] = '{32'hD000_0000, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 18'h010, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{32'hC000_0005, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 18'h005, 1'b0, 1'b0, 1'b0};
      vecs[16] = '{32'h5000_0000, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 18'h005, 1'b0, 1'b1, 1'b0};
      vecs[17] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 18'h005, 1'b0, 1'b0, 1'b0};
      // len=4 with FIFO full on the 2nd payload
      vecs[18] = '{32'hD000_0004, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 18'h005, 1'b1, 1'b0, 1'b0};
      vecs[19] = '{32'h1111_0001, 1'b1, 1'b0, 1'b1, 32'h1111_0001, 1'b0, 18'h005, 1'b1, 1'b0, 1'b0};
      vecs[20] = '{32'h2222_0002, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 18'h005, 1'b1, 1'b0, 1'b1};
      vecs[21] = '{32'hD333_0003, 1'b1, 1'b0, 1'b1, 32'hD333_0003, 1'b0, 18'h005, 1'b1, 1'b0, 1'b1};
      vecs[22] = '{32'h4444_0004, 1'b1, 1'b0, 1'b1, 32'h4444_0004, 1'b0, 18'h005, 1'b0, 1'b0, 1'b1};
      vecs[23] = '{32'hC000_3FFF, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 18'h3FFF, 1'b0, 1'b0, 1'b1};

      bus.rx_data         = 32'h0;
      bus.rx_data_src_rdy = 1'b0;
      bus.fifo_full       = 1'b0;

      // Reset state
      drive(32'hC000_0042, 1'b1, 1'b0, 1'b1);
      drive(32'hC000_0042, 1'b1, 1'b0, 1'b1);
      chk("reset.fifo_wr", 32'(bus.fifo_wr), 32'd0);
      chk("reset.fifo_dat", bus.fifo_dat, 32'd0);
      chk("reset.slots", 32'(bus.partner_empty_slots), 32'd0);
      chk("reset.slots_valid", 32'(bus.partner_empty_slots_valid), 32'd0);
      chk("reset.in_packet", 32'(bus.in_packet), 32'd0);
      chk("reset.err_overflow", 32'(bus.err_overflow), 32'd0);
      chk("reset.err_header", 32'(bus.err_header), 32'd0);

      for (int i = 0; i < NVEC; i++) begin
         run_vec(i, vecs[i]);
      end

      // Reset mid-packet: clears sticky error and abandons the packet
      drive(32'h0, 1'b0, 1'b0, 1'b1);
      chk("rst2.err_overflow", 32'(bus.err_overflow), 32'd0);
      drive(32'hD000_0005, 1'b1, 1'b0, 1'b0);
      chk("mid.in_packet_hdr", 32'(bus.in_packet), 32'd1);
      sb_q.push_back(32'h7777_0001);
      drive(32'h7777_0001, 1'b1, 1'b0, 1'b0);
      check_fifo("mid.p1", 1'b1);
      sb_q.push_back(32'h7777_0002);
      drive(32'h7777_0002, 1'b1, 1'b0, 1'b0);
      check_fifo("mid.p2", 1'b1);
      chk("mid.in_packet_p2", 32'(bus.in_packet), 32'd1);
`ifdef AURORA_RX_STATS_EN
      chk("stat.data_words", bus.stat_data_words, 32'd2);
      chk("stat.pkts", bus.stat_pkts, 32'd1);
      chk("stat.ctrl_words0", bus.stat_ctrl_words, 32'd0);
`endif
      // Reset wins over a valid control word in the same cycle
      drive(32'hC000_0099, 1'b1, 1'b0, 1'b1);
      check_fifo("mid.rst", 1'b0);
      chk("mid.rst.in_packet", 32'(bus.in_packet), 32'd0);
      chk("mid.rst.slots", 32'(bus.partner_empty_slots), 32'd0);
      chk("mid.rst.slots_valid", 32'(bus.partner_empty_slots_valid), 32'd0);
`ifdef AURORA_RX_STATS_EN
      chk("stat.pkts_rst", bus.stat_pkts, 32'd0);
      chk("stat.data_rst", bus.stat_data_words, 32'd0);
`endif
      drive(32'hC000_0007, 1'b1, 1'b0, 1'b0);
      check_fifo("post.ctrl", 1'b0);
      chk("post.slots", 32'(bus.partner_empty_slots), 32'd7);
      chk("post.slots_valid", 32'(bus.partner_empty_slots_valid), 32'd1);
      chk("post.in_packet", 32'(bus.in_packet), 32'd0);
`ifdef AURORA_RX_STATS_EN
      chk("stat.ctrl_words1", bus.stat_ctrl_words, 32'd1);
`endif
      drive(32'h0, 1'b0, 1'b0, 1'b0);
      chk("post.slots_valid_pulse", 32'(bus.partner_empty_slots_valid), 32'd0);
      chk("post.slots_hold", 32'(bus.partner_empty_slots), 32'd7);

      chk("scoreboard.empty", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
